// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Purpose  : Five-state multicycle CPU controller (FETCH/DECODE/EXEC/MEM/WB).
//            Every output is a register, loaded from the next-state value so
//            that each output is valid for the whole cycle spent in a state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int DATA_WIDTH     = 16,
  parameter int ALU_OP_WIDTH   = 3,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     instr,
  input  logic                      instr_valid,
  input  logic                      mem_ready,
  input  logic                      alu_zero,
  input  logic                      alu_neg,
  output logic [DATA_WIDTH-1:0]     pc,
  output logic                      instr_req,
  output logic [ALU_OP_WIDTH-1:0]   alu_operator,
  output logic [REG_ADDR_WIDTH-1:0] reg_file_addr_a,
  output logic [REG_ADDR_WIDTH-1:0] reg_file_addr_b,
  output logic [REG_ADDR_WIDTH-1:0] reg_file_addr_c,
  output logic                      reg_we,
  output logic                      im_en,
  output logic [DATA_WIDTH-1:0]     imm,
  output logic                      mem_req,
  output logic                      mem_we_n
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_MULT = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_MOVI = 4'h7;
  localparam logic [3:0] OP_NAND = 4'h8;
  localparam logic [3:0] OP_DIV  = 4'h9;
  localparam logic [3:0] OP_MOD  = 4'hA;
  localparam logic [3:0] OP_ROTL = 4'hB;
  localparam logic [3:0] OP_BLE  = 4'hC;
  localparam logic [3:0] OP_BGE  = 4'hD;
  localparam logic [3:0] OP_BEQ  = 4'hE;
  localparam logic [3:0] OP_J    = 4'hF;

  state_t state, next_state;

  // Latched instruction; only the low 16 bits carry fields.
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  in_opcode;

  assign opcode    = ir[15:12];
  assign in_opcode = instr[15:12];

  // Decode of the incoming instruction, loaded into the outputs on accept
  logic [ALU_OP_WIDTH-1:0]   dec_op;
  logic                      dec_im;
  logic [REG_ADDR_WIDTH-1:0] dec_c;

  // Next-state and pc update
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] pc_inc;
  logic [DATA_WIDTH-1:0] br_off;
  logic [DATA_WIDTH-1:0] jmp_tgt;
  logic                  br_taken;

  assign pc_inc  = pc + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  assign br_off  = {{(DATA_WIDTH-4){ir[3]}}, ir[3:0]};
  assign jmp_tgt = {{(DATA_WIDTH-12){1'b0}}, ir[11:0]};

  // Opcode decode of the instruction presented in FETCH
  always_comb begin
    dec_op = '1;
    dec_im = 1'b0;
    case (in_opcode)
      OP_ADD:  dec_op = ALU_OP_WIDTH'(0);
      OP_ADDI: begin dec_op = ALU_OP_WIDTH'(0); dec_im = 1'b1; end
      OP_SW:   begin dec_op = ALU_OP_WIDTH'(0); dec_im = 1'b1; end
      OP_LW:   begin dec_op = ALU_OP_WIDTH'(0); dec_im = 1'b1; end
      OP_SUB:  dec_op = ALU_OP_WIDTH'(1);
      OP_SUBI: begin dec_op = ALU_OP_WIDTH'(1); dec_im = 1'b1; end
      OP_BLE:  dec_op = ALU_OP_WIDTH'(1);
      OP_BGE:  dec_op = ALU_OP_WIDTH'(1);
      OP_BEQ:  dec_op = ALU_OP_WIDTH'(1);
      OP_MULT: dec_op = ALU_OP_WIDTH'(2);
      OP_NAND: dec_op = ALU_OP_WIDTH'(3);
      OP_DIV:  dec_op = ALU_OP_WIDTH'(4);
      OP_MOD:  dec_op = ALU_OP_WIDTH'(5);
      OP_ROTL: dec_op = ALU_OP_WIDTH'(6);
      OP_MOVI: begin dec_op = '1; dec_im = 1'b1; end
      default: dec_op = '1;
    endcase
    // Immediate forms write back to op1; others to op3
    dec_c = dec_im ? REG_ADDR_WIDTH'(instr[11:8]) : REG_ADDR_WIDTH'(instr[3:0]);
  end

  // Branch condition evaluated from the ALU flags during EXEC
  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      OP_BLE:  br_taken = alu_zero | alu_neg;
      OP_BGE:  br_taken = ~alu_neg;
      OP_BEQ:  br_taken = alu_zero;
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state and next-pc selection
  always_comb begin
    next_state = state;
    pc_next    = pc;
    case (state)
      FETCH: begin
        if (instr_valid) next_state = DECODE;
      end
      DECODE: next_state = EXEC;
      EXEC: begin
        case (opcode)
          OP_SW, OP_LW: next_state = MEM;
          OP_BLE, OP_BGE, OP_BEQ: begin
            next_state = FETCH;
            pc_next    = br_taken ? (pc_inc + br_off) : pc_inc;
          end
          OP_J: begin
            next_state = FETCH;
            pc_next    = jmp_tgt;
          end
          default: next_state = WB;
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            next_state = FETCH;
            pc_next    = pc_inc;
          end else begin
            next_state = WB;
          end
        end
      end
      WB: begin
        next_state = FETCH;
        pc_next    = pc_inc;
      end
      default: next_state = FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  // Registered outputs, derived from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc              <= '0;
      ir              <= '0;
      instr_req       <= 1'b1;
      alu_operator    <= '1;
      reg_file_addr_a <= '0;
      reg_file_addr_b <= '0;
      reg_file_addr_c <= '0;
      imm             <= '0;
      im_en           <= 1'b0;
      reg_we          <= 1'b0;
      mem_req         <= 1'b0;
      mem_we_n        <= 1'b1;
    end else begin
      pc        <= pc_next;
      instr_req <= (next_state == FETCH);
      reg_we    <= (next_state == WB);
      mem_req   <= (next_state == MEM);
      mem_we_n  <= ~((next_state == MEM) && (opcode == OP_SW));
      if (state == FETCH && instr_valid) begin
        ir              <= instr[15:0];
        alu_operator    <= dec_op;
        im_en           <= dec_im;
        reg_file_addr_a <= REG_ADDR_WIDTH'(instr[11:8]);
        reg_file_addr_b <= REG_ADDR_WIDTH'(instr[7:4]);
        reg_file_addr_c <= dec_c;
        imm             <= {{(DATA_WIDTH-8){instr[7]}}, instr[7:0]};
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Self-checking bench for multicycle_control: a table of directed
//            instructions with hand-computed results, plus reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic        alu_neg = 1'b0;
  logic [15:0] pc;
  logic        instr_req;
  logic [2:0]  alu_operator;
  logic [3:0]  reg_file_addr_a, reg_file_addr_b, reg_file_addr_c;
  logic        reg_we, im_en, mem_req, mem_we_n;
  logic [15:0] imm;

  int pass_cnt = 0;
  int total    = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .pc(pc), .instr_req(instr_req), .alu_operator(alu_operator),
    .reg_file_addr_a(reg_file_addr_a), .reg_file_addr_b(reg_file_addr_b),
    .reg_file_addr_c(reg_file_addr_c), .reg_we(reg_we), .im_en(im_en),
    .imm(imm), .mem_req(mem_req), .mem_we_n(mem_we_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    logic        z;
    logic        n;
    int          wt;   // mem wait cycles before mem_ready
    logic [2:0]  op;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  c;
    logic        im;
    logic        ci;   // check imm
    logic [15:0] imm;
    int          lat;
    int          we;
    int          mr;   // cycles with mem_req
    int          wl;   // cycles with mem_we_n low
    logic [15:0] pc;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Run one instruction from FETCH back to FETCH and compare against v
  task automatic run_instr(input int idx, input vec_t v);
    int lat, we_c, mr_c, wl_c, guard;
    logic [3:0] wbc, a_d, b_d, c_d;
    logic [2:0] op_d;
    logic im_d, req_d;
    logic [15:0] imm_d;
    guard = 0;
    while (!instr_req && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!instr_req) chk($sformatf("v%0d_fetch_wait", idx), {31'b0, instr_req}, 1);
    instr = v.ins; instr_valid = 1'b1; alu_zero = v.z; alu_neg = v.n; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 16'hFFFF;
    op_d = alu_operator; a_d = reg_file_addr_a; b_d = reg_file_addr_b;
    c_d = reg_file_addr_c; im_d = im_en; imm_d = imm; req_d = instr_req;
    lat = 1; we_c = 0; mr_c = 0; wl_c = 0; wbc = '0;
    while (!instr_req && lat < 60) begin
      if (reg_we) begin we_c++; wbc = reg_file_addr_c; end
      if (!mem_we_n) wl_c++;
      if (mem_req) begin
        mr_c++;
        mem_ready = (mr_c > v.wt);
      end else begin
        mem_ready = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    mem_ready = 1'b0;
    chk($sformatf("v%0d_alu_op", idx), {29'b0, op_d}, {29'b0, v.op});
    chk($sformatf("v%0d_addr_a", idx), {28'b0, a_d}, {28'b0, v.a});
    chk($sformatf("v%0d_addr_b", idx), {28'b0, b_d}, {28'b0, v.b});
    chk($sformatf("v%0d_addr_c", idx), {28'b0, c_d}, {28'b0, v.c});
    chk($sformatf("v%0d_im_en", idx), {31'b0, im_d}, {31'b0, v.im});
    chk($sformatf("v%0d_req_in_decode", idx), {31'b0, req_d}, 0);
    if (v.ci) chk($sformatf("v%0d_imm", idx), {16'b0, imm_d}, {16'b0, v.imm});
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_reg_we_cnt", idx), we_c, v.we);
    chk($sformatf("v%0d_mem_req_cnt", idx), mr_c, v.mr);
    chk($sformatf("v%0d_we_n_low_cnt", idx), wl_c, v.wl);
    chk($sformatf("v%0d_pc", idx), {16'b0, pc}, {16'b0, v.pc});
    if (v.we == 1) chk($sformatf("v%0d_wb_addr_c", idx), {28'b0, wbc}, {28'b0, v.c});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    //          ins      z     n    wt  op    a     b     c     im    ci    imm        lat we mr wl pc
    vecs[0]  = '{16'h0123,1'b0,1'b0,0, 3'd0,4'h1,4'h2,4'h3,1'b0,1'b0,16'h0000, 4,1,0,0, 16'h0001};
    vecs[1]  = '{16'h1345,1'b0,1'b0,0, 3'd0,4'h3,4'h4,4'h3,1'b1,1'b1,16'h0045, 4,1,0,0, 16'h0002};
    vecs[2]  = '{16'h2456,1'b0,1'b0,0, 3'd1,4'h4,4'h5,4'h6,1'b0,1'b0,16'h0000, 4,1,0,0, 16'h0003};
    vecs[3]  = '{16'h31F0,1'b0,1'b0,0, 3'd1,4'h1,4'hF,4'h1,1'b1,1'b1,16'hFFF0, 4,1,0,0, 16'h0004};
    vecs[4]  = '{16'h4789,1'b0,1'b0,0, 3'd2,4'h7,4'h8,4'h9,1'b0,1'b0,16'h0000, 4,1,0,0, 16'h0005};
    vecs[5]  = '{16'h8ABC,1'b0,1'b0,0, 3'd3,4'hA,4'hB,4'hC,1'b0,1'b0,16'h0000, 4,1,0,0, 16'h0006};
    vecs[6]  = '{16'h9123,1'b0,1'b0,0, 3'd4,4'h1,4'h2,4'h3,1'b0,1'b0,16'h0000, 4,1,0,0, 16'h0007};
    vecs[7]  = '{16'hA321,1'b0,1'b0,0, 3'd5,4'h3,4'h2,4'h1,1'b0,1'b0,16'h0000, 4,1,0,0, 16'h0008};
    vecs[8]  = '{16'hB654,1'b0,1'b0,0, 3'd6,4'h6,4'h5,4'h4,1'b0,1'b0,16'h0000, 4,1,0,0, 16'h0009};
    vecs[9]  = '{16'h7A7F,1'b0,1'b0,0, 3'd7,4'hA,4'h7,4'hA,1'b1,1'b1,16'h007F, 4,1,0,0, 16'h000A};
    vecs[10] = '{16'hF005,1'b0,1'b0,0, 3'd7,4'h0,4'h0,4'h5,1'b0,1'b0,16'h0000, 3,0,0,0, 16'h0005};
    vecs[11] = '{16'hE12F,1'b1,1'b0,0, 3'd1,4'h1,4'h2,4'hF,1'b0,1'b0,16'h0000, 3,0,0,0, 16'h0005};
    vecs[12] = '{16'hE12F,1'b0,1'b0,0, 3'd1,4'h1,4'h2,4'hF,1'b0,1'b0,16'h0000, 3,0,0,0, 16'h0006};
    vecs[13] = '{16'hC342,1'b0,1'b1,0, 3'd1,4'h3,4'h4,4'h2,1'b0,1'b0,16'h0000, 3,0,0,0, 16'h0009};
    vecs[14] = '{16'hC342,1'b0,1'b0,0, 3'd1,4'h3,4'h4,4'h2,1'b0,1'b0,16'h0000, 3,0,0,0, 16'h000A};
    vecs[15] = '{16'hD347,1'b0,1'b0,0, 3'd1,4'h3,4'h4,4'h7,1'b0,1'b0,16'h0000, 3,0,0,0, 16'h0012};
    vecs[16] = '{16'hD347,1'b0,1'b1,0, 3'd1,4'h3,4'h4,4'h7,1'b0,1'b0,16'h0000, 3,0,0,0, 16'h0013};
    vecs[17] = '{16'hC348,1'b1,1'b0,0, 3'd1,4'h3,4'h4,4'h8,1'b0,1'b0,16'h0000, 3,0,0,0, 16'h000C};
    vecs[18] = '{16'h6380,1'b0,1'b0,3, 3'd0,4'h3,4'h8,4'h3,1'b1,1'b1,16'hFF80, 8,1,4,0, 16'h000D};
    vecs[19] = '{16'h5210,1'b0,1'b0,1, 3'd0,4'h2,4'h1,4'h2,1'b1,1'b1,16'h0010, 5,0,2,2, 16'h000E};
    vecs[20] = '{16'h5210,1'b0,1'b0,0, 3'd0,4'h2,4'h1,4'h2,1'b1,1'b1,16'h0010, 4,0,1,1, 16'h000F};
    vecs[21] = '{16'hF000,1'b0,1'b0,0, 3'd7,4'h0,4'h0,4'h0,1'b0,1'b0,16'h0000, 3,0,0,0, 16'h0000};
    vecs[22] = '{16'hE00E,1'b1,1'b0,0, 3'd1,4'h0,4'h0,4'hE,1'b0,1'b0,16'h0000, 3,0,0,0, 16'hFFFF};
    vecs[23] = '{16'h1101,1'b0,1'b0,0, 3'd0,4'h1,4'h0,4'h1,1'b1,1'b1,16'h0001, 4,1,0,0, 16'h0000};
    vecs[24] = '{16'hFABC,1'b0,1'b0,0, 3'd7,4'hA,4'hB,4'hC,1'b0,1'b0,16'h0000, 3,0,0,0, 16'h0ABC};

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_pc", {16'b0, pc}, 0);
    chk("rst_instr_req", {31'b0, instr_req}, 1);
    chk("rst_alu_op", {29'b0, alu_operator}, 32'h7);
    chk("rst_addrs", {20'b0, reg_file_addr_a, reg_file_addr_b, reg_file_addr_c}, 0);
    chk("rst_imm", {16'b0, imm}, 0);
    chk("rst_ctl", {28'b0, reg_we, mem_req, mem_we_n, im_en}, 32'b0010);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 25; i++) run_instr(i, vecs[i]);

    // Reset in the middle of a stalled SW: access and pc update are dropped
    instr = 16'h5210; instr_valid = 1'b1; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    guard = 0;
    while (!mem_req && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("sw_mem_req", {31'b0, mem_req}, 1);
    chk("sw_we_n", {31'b0, mem_we_n}, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midmem_rst_mem_req", {31'b0, mem_req}, 0);
    chk("midmem_rst_we_n", {31'b0, mem_we_n}, 1);
    chk("midmem_rst_pc", {16'b0, pc}, 0);
    chk("midmem_rst_instr_req", {31'b0, instr_req}, 1);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_hold_reg_we", {31'b0, reg_we}, 0);
    chk("rst_hold_pc", {16'b0, pc}, 0);
    mem_ready = 1'b0;
    rst = 1'b0;

    // Fetch resumes right after reset release
    run_instr(100, vecs[0]);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
